cpu_control_unit: RTL and testbench

Multi-cycle fetch/decode/sequencing controller for the 8-bit processor. It sits directly upstream of the ALU and register file. It fetches 32-bit instructions over a ready handshake and decodes them into ALU `SELECT`, operand-mux and register-file controls. It consumes the ALU `ZERO` flag to resolve branches, and owns the program counter.

---
 rtl/cpu_control_unit.sv | 192 +++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback controller for the 8-bit processor.
// Build option: define CTRL_HALT_ON_ILLEGAL_EN to halt on an undefined opcode (default: execute it as a NOP).
module cpu_control_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        IMEM_READY,
  input  logic        ZERO,
  output logic        IMEM_READ,
  output logic [31:0] PC,
  output logic [2:0]  ALUOP,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic [2:0]  WRITEREG,
  output logic        WRITEENABLE,
  output logic [7:0]  IMMEDIATE,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic        ILLEGAL
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
`ifdef CTRL_HALT_ON_ILLEGAL_EN
    , S_HALT
`endif
  } state_e;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_SRL   = 8'h08;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        taken_q, taken_d;
  logic [2:0]  aluop_q, aluop_d;
  logic [2:0]  rr1_q, rr1_d;
  logic [2:0]  rr2_q, rr2_d;
  logic [2:0]  wr_q, wr_d;
  logic [7:0]  imm_q, imm_d;
  logic        imm_sel_q, imm_sel_d;
  logic        neg_sel_q, neg_sel_d;
  logic        we_q, we_d;
  logic        illegal_q, illegal_d;

  logic [7:0]  opcode;
  logic [2:0]  dec_aluop;
  logic        dec_imm_sel;
  logic        dec_neg_sel;
  logic        dec_writes;
  logic        dec_legal;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic        unused_ir_bits;

  assign opcode         = ir_q[31:24];
  assign pc_plus4       = pc_q + 32'd4;
  assign branch_target  = pc_plus4 + {{22{ir_q[23]}}, ir_q[23:16], 2'b00};
  assign unused_ir_bits = ^ir_q[15:11];

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    dec_aluop   = 3'b000;
    dec_imm_sel = 1'b0;
    dec_neg_sel = 1'b0;
    dec_writes  = 1'b0;
    dec_legal   = 1'b1;
    case (opcode)
      OP_LOADI: begin dec_imm_sel = 1'b1; dec_writes = 1'b1; end
      OP_MOV:   dec_writes = 1'b1;
      OP_ADD:   begin dec_aluop = 3'b001; dec_writes = 1'b1; end
      OP_SUB:   begin dec_aluop = 3'b001; dec_neg_sel = 1'b1; dec_writes = 1'b1; end
      OP_AND:   begin dec_aluop = 3'b010; dec_writes = 1'b1; end
      OP_OR:    begin dec_aluop = 3'b011; dec_writes = 1'b1; end
      OP_J:     ;
      OP_BEQ:   begin dec_aluop = 3'b001; dec_neg_sel = 1'b1; end
      OP_SRL:   begin dec_aluop = 3'b100; dec_imm_sel = 1'b1; dec_writes = 1'b1; end
      default:  dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    taken_d   = taken_q;
    aluop_d   = aluop_q;
    rr1_d     = rr1_q;
    rr2_d     = rr2_q;
    wr_d      = wr_q;
    imm_d     = imm_q;
    imm_sel_d = imm_sel_q;
    neg_sel_d = neg_sel_q;
    we_d      = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: begin
        if (IMEM_READY) begin
          ir_d    = INSTRUCTION;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        aluop_d   = dec_aluop;
        imm_sel_d = dec_imm_sel;
        neg_sel_d = dec_neg_sel;
        rr1_d     = ir_q[10:8];
        rr2_d     = ir_q[2:0];
        wr_d      = ir_q[18:16];
        // srl places its 3-bit shift amount on DATA2[7:5]
        imm_d     = (opcode == OP_SRL) ? {ir_q[2:0], 5'b0_0000} : ir_q[7:0];
        if (!dec_legal) illegal_d = 1'b1;
        state_d   = S_EXECUTE;
      end
      S_EXECUTE: begin
        taken_d = (opcode == OP_BEQ) & ZERO;
        we_d    = dec_writes;
`ifdef CTRL_HALT_ON_ILLEGAL_EN
        state_d = dec_legal ? S_WRITEBACK : S_HALT;
`else
        state_d = S_WRITEBACK;
`endif
      end
      S_WRITEBACK: begin
        pc_d    = ((opcode == OP_J) || taken_q) ? branch_target : pc_plus4;
        state_d = S_FETCH;
      end
`ifdef CTRL_HALT_ON_ILLEGAL_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      taken_q   <= 1'b0;
      aluop_q   <= '0;
      rr1_q     <= '0;
      rr2_q     <= '0;
      wr_q      <= '0;
      imm_q     <= '0;
      imm_sel_q <= 1'b0;
      neg_sel_q <= 1'b0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      taken_q   <= taken_d;
      aluop_q   <= aluop_d;
      rr1_q     <= rr1_d;
      rr2_q     <= rr2_d;
      wr_q      <= wr_d;
      imm_q     <= imm_d;
      imm_sel_q <= imm_sel_d;
      neg_sel_q <= neg_sel_d;
      we_q      <= we_d;
      illegal_q <= illegal_d;
    end
  end

  assign IMEM_READ   = (state_q == S_FETCH) & ~RESET;
  assign PC          = pc_q;
  assign ALUOP       = aluop_q;
  assign READREG1    = rr1_q;
  assign READREG2    = rr2_q;
  assign WRITEREG    = wr_q;
  assign WRITEENABLE = we_q;
  assign IMMEDIATE   = imm_q;
  assign IMM_SEL     = imm_sel_q;
  assign NEG_SEL     = neg_sel_q;
  assign ILLEGAL     = illegal_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: expected controls/PC pushed at fetch, popped at writeback.
module tb_cpu_control_unit;

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        IMEM_READY;
  logic        ZERO;
  logic        IMEM_READ;
  logic [31:0] PC;
  logic [2:0]  ALUOP;
  logic [2:0]  READREG1;
  logic [2:0]  READREG2;
  logic [2:0]  WRITEREG;
  logic        WRITEENABLE;
  logic [7:0]  IMMEDIATE;
  logic        IMM_SEL;
  logic        NEG_SEL;
  logic        ILLEGAL;

  cpu_control_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .IMEM_READY(IMEM_READY),
    .ZERO(ZERO), .IMEM_READ(IMEM_READ), .PC(PC), .ALUOP(ALUOP),
    .READREG1(READREG1), .READREG2(READREG2), .WRITEREG(WRITEREG),
    .WRITEENABLE(WRITEENABLE), .IMMEDIATE(IMMEDIATE), .IMM_SEL(IMM_SEL),
    .NEG_SEL(NEG_SEL), .ILLEGAL(ILLEGAL)
  );

  typedef struct packed {
    logic [2:0]  aluop;
    logic        imm_sel;
    logic        neg_sel;
    logic        we;
    logic        illegal;
    logic [7:0]  imm;
    logic [2:0]  rr1;
    logic [2:0]  rr2;
    logic [2:0]  wr;
    logic [31:0] pc_next;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_pc;
  logic        m_illegal;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode written straight from the opcode table.
  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc, input logic zero);
    exp_t        e;
    logic [7:0]  off;
    logic [31:0] seq_pc;
    logic [31:0] jmp_pc;
    off    = instr[23:16];
    seq_pc = pc + 32'd4;
    jmp_pc = seq_pc + 32'(int'($signed(off)) * 4);
    e = '0;
    e.rr1 = instr[10:8];
    e.rr2 = instr[2:0];
    e.wr  = instr[18:16];
    e.imm = instr[7:0];
    e.pc_next = seq_pc;
    case (instr[31:24])
      8'h00: begin e.aluop = 3'b000; e.imm_sel = 1'b1; e.we = 1'b1; end
      8'h01: begin e.aluop = 3'b000; e.we = 1'b1; end
      8'h02: begin e.aluop = 3'b001; e.we = 1'b1; end
      8'h03: begin e.aluop = 3'b001; e.neg_sel = 1'b1; e.we = 1'b1; end
      8'h04: begin e.aluop = 3'b010; e.we = 1'b1; end
      8'h05: begin e.aluop = 3'b011; e.we = 1'b1; end
      8'h06: e.pc_next = jmp_pc;
      8'h07: begin e.aluop = 3'b001; e.neg_sel = 1'b1; if (zero) e.pc_next = jmp_pc; end
      8'h08: begin e.aluop = 3'b100; e.imm_sel = 1'b1; e.we = 1'b1; e.imm = 8'(instr[2:0]) << 5; end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},    PC, 32'h0);
    check({tag, "_rd"},    {31'b0, IMEM_READ}, 32'd0);
    check({tag, "_aluop"}, {29'b0, ALUOP}, 32'd0);
    check({tag, "_rr1"},   {29'b0, READREG1}, 32'd0);
    check({tag, "_rr2"},   {29'b0, READREG2}, 32'd0);
    check({tag, "_wr"},    {29'b0, WRITEREG}, 32'd0);
    check({tag, "_imm"},   {24'b0, IMMEDIATE}, 32'd0);
    check({tag, "_isel"},  {31'b0, IMM_SEL}, 32'd0);
    check({tag, "_nsel"},  {31'b0, NEG_SEL}, 32'd0);
    check({tag, "_we"},    {31'b0, WRITEENABLE}, 32'd0);
    check({tag, "_ill"},   {31'b0, ILLEGAL}, 32'd0);
  endtask

  task automatic check_ctrl(input string tag, input exp_t e);
    check({tag, "_aluop"}, {29'b0, ALUOP}, {29'b0, e.aluop});
    check({tag, "_isel"},  {31'b0, IMM_SEL}, {31'b0, e.imm_sel});
    check({tag, "_nsel"},  {31'b0, NEG_SEL}, {31'b0, e.neg_sel});
    check({tag, "_imm"},   {24'b0, IMMEDIATE}, {24'b0, e.imm});
    check({tag, "_rr1"},   {29'b0, READREG1}, {29'b0, e.rr1});
    check({tag, "_rr2"},   {29'b0, READREG2}, {29'b0, e.rr2});
    check({tag, "_wr"},    {29'b0, WRITEREG}, {29'b0, e.wr});
  endtask

  // Entered at a negedge inside the first FETCH cycle; leaves at the negedge of the next FETCH cycle.
  task automatic do_instr(input logic [31:0] instr, input int delay, input logic zero);
    exp_t e;
    exp_t f;
    e = model(instr, m_pc, zero);
    check("fetch_rd", {31'b0, IMEM_READ}, 32'd1);
    check("fetch_pc", PC, m_pc);
    check("fetch_we", {31'b0, WRITEENABLE}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      IMEM_READY  = 1'b0;
      INSTRUCTION = $urandom;
      @(negedge CLK);
      check("wait_rd", {31'b0, IMEM_READ}, 32'd1);
      check("wait_pc", PC, m_pc);
      check("wait_we", {31'b0, WRITEENABLE}, 32'd0);
    end
    INSTRUCTION = instr;
    IMEM_READY  = 1'b1;
    sb_q.push_back(e);
    @(negedge CLK);  // DECODE: ready/instruction must now be ignored
    IMEM_READY  = 1'($urandom_range(0, 1));
    INSTRUCTION = $urandom;
    check("dec_rd",  {31'b0, IMEM_READ}, 32'd0);
    check("dec_we",  {31'b0, WRITEENABLE}, 32'd0);
    check("dec_ill", {31'b0, ILLEGAL}, {31'b0, m_illegal});
    @(negedge CLK);  // EXECUTE
    ZERO = zero;
    f = sb_q[0];
    m_illegal = m_illegal | f.illegal;
    check("ex_ill", {31'b0, ILLEGAL}, {31'b0, m_illegal});
    check("ex_we",  {31'b0, WRITEENABLE}, 32'd0);
    if (!f.illegal) check_ctrl("ex", f);
`ifdef CTRL_HALT_ON_ILLEGAL_EN
    if (f.illegal) begin
      void'(sb_q.pop_front());
      IMEM_READY = 1'b1;
      for (int i = 0; i < 24; i++) begin
        @(negedge CLK);
        check("halt_rd",  {31'b0, IMEM_READ}, 32'd0);
        check("halt_we",  {31'b0, WRITEENABLE}, 32'd0);
        check("halt_pc",  PC, m_pc);
        check("halt_ill", {31'b0, ILLEGAL}, 32'd1);
      end
      return;
    end
`endif
    @(negedge CLK);  // WRITEBACK
    ZERO       = ~zero;
    IMEM_READY = 1'b0;
    f = sb_q.pop_front();
    check("wb_we",  {31'b0, WRITEENABLE}, {31'b0, f.we});
    check("wb_rd",  {31'b0, IMEM_READ}, 32'd0);
    check("wb_pc",  PC, m_pc);
    check("wb_ill", {31'b0, ILLEGAL}, {31'b0, m_illegal});
    if (!f.illegal) check("wb_aluop", {29'b0, ALUOP}, {29'b0, f.aluop});
    @(negedge CLK);  // next FETCH
    check("next_pc", PC, f.pc_next);
    check("next_we", {31'b0, WRITEENABLE}, 32'd0);
    m_pc = f.pc_next;
  endtask

  initial begin
    RESET       = 1'b1;
    INSTRUCTION = '0;
    IMEM_READY  = 1'b0;
    ZERO        = 1'b0;
    m_pc        = 32'h0;
    m_illegal   = 1'b0;
    #2;
    check_reset_outputs("por");
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("por_rel_rd", {31'b0, IMEM_READ}, 32'd1);

    // add aborted by reset during EXECUTE
    INSTRUCTION = 32'h0201_0102;
    IMEM_READY  = 1'b1;
    @(negedge CLK);
    IMEM_READY = 1'b0;
    @(negedge CLK);
    check("abort_ex_aluop", {29'b0, ALUOP}, 32'd1);
    RESET = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge CLK);
    check("abort_we", {31'b0, WRITEENABLE}, 32'd0);
    check("abort_rd", {31'b0, IMEM_READ}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("abort_rel_rd", {31'b0, IMEM_READ}, 32'd1);

    do_instr(32'h0002_002A, 3, 1'b0);  // loadi r2,0x2A  PC 0 -> 4
    do_instr(32'h06FD_0000, 0, 1'b0);  // j -3          PC 4 -> FFFFFFFC
    do_instr(32'h0600_0000, 1, 1'b1);  // j 0 wraps     -> 0
    do_instr(32'h0303_0102, 0, 1'b0);  // sub r3,r1,r2  -> 4
    do_instr(32'h0801_0405, 2, 1'b0);  // srl r1,r4,5   -> 8
    do_instr(32'h0207_0304, 0, 1'b1);  // add           -> C
    do_instr(32'h0104_0500, 0, 1'b0);  // mov           -> 10
    do_instr(32'h07FE_0102, 0, 1'b1);  // beq taken     -> C
    do_instr(32'h0405_0607, 1, 1'b1);  // and           -> 10
    do_instr(32'h07FE_0102, 0, 1'b0);  // beq not taken -> 14
    do_instr(32'h0506_0102, 0, 1'b0);  // or            -> 18
    do_instr(32'h0601_0000, 0, 1'b0);  // j +1          -> 20
    do_instr(32'hFF00_0000, 0, 1'b0);  // illegal at 0x20
`ifndef CTRL_HALT_ON_ILLEGAL_EN
    do_instr(32'h0005_007F, 1, 1'b0);  // fetch resumes, ILLEGAL stays set
    do_instr(32'h0908_0000, 0, 1'b0);  // another undefined opcode
`endif
    check("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
